// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/subtract computed one nibble per clock,
// least-significant nibble first, between valid/ready source and sink.
// Optional build macro NIBBLE_SERIAL_ADDER_OVF_EN adds the signed overflow
// output ovf, registered alongside sum/cout.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one nibble add per cycle, NIB cycles total
// DONE  | result held on sum/cout, out_valid=1 until out_ready

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, res_q;
    logic              carry_q;
    logic [CW-1:0]     cnt_q;
    logic [4:0]        step;
    logic [3:0]        low3;
    logic              accept;
    logic              last;

    // One nibble of addition; low3 exposes the carry into the nibble MSB,
    // which on the final step is the carry into the word MSB.
    always_comb begin
        step   = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, carry_q};
        low3   = {1'b0, a_q[2:0]} + {1'b0, b_q[2:0]} + {3'b0, carry_q};
        accept = in_valid && (state_q == IDLE);
        last   = (state_q == RUN) && (cnt_q == LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and per-nibble shift datapath; sum/cout only update on
    // the final step so they stay stable outside of a completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_q     <= a_q >> 4;
            b_q     <= b_q >> 4;
            carry_q <= step[4];
            cnt_q   <= cnt_q + CW'(1);
            res_q   <= {step[3:0], res_q[WIDTH-1:4]};
            if (last) begin
                sum  <= {step[3:0], res_q[WIDTH-1:4]};
                cout <= step[4];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                ovf  <= low3[3] ^ step[4];
`endif
            end
        end
    end

`ifndef NIBBLE_SERIAL_ADDER_OVF_EN
    // low3 only feeds the overflow flag; keep it referenced in the base build.
    logic unused_low3;
    assign unused_low3 = ^low3;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16). Inputs are driven and
// outputs sampled on the falling clock edge.

module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        cin, sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one operation, accept it, scramble the inputs, and wait for
    // out_valid; checks latency and the result but does not pop it.
    task automatic op_run(input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic sv,
                          input logic [15:0] exp_sum, input logic exp_cout);
        int n;
        @(negedge clk);
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a = ~av; b = 16'h5A5A; cin = ~cv; sub = ~sv;
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        check("in_ready_after_accept", {31'b0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (!out_valid) check("busy_in_run", {31'b0, busy}, 32'd1);
        end
        check("latency", n, 32'd4);
        check("sum", {16'b0, sum}, {16'b0, exp_sum});
        check("cout", {31'b0, cout}, {31'b0, exp_cout});
    endtask

    task automatic pop(input logic [15:0] exp_sum);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_pop", {31'b0, out_valid}, 32'd0);
        check("in_ready_after_pop", {31'b0, in_ready}, 32'd1);
        check("busy_after_pop", {31'b0, busy}, 32'd0);
        check("sum_held_after_pop", {16'b0, sum}, {16'b0, exp_sum});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sum", {16'b0, sum}, 32'd0);
        check("rst_cout", {31'b0, cout}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        op_run(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
        pop(16'h5555);
        op_run(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        pop(16'h0000);
        op_run(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0);
        pop(16'h0001);
        op_run(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        pop(16'hFFFE);
        op_run(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
        pop(16'h0002);

        // Backpressure: result held, new operands ignored while in DONE.
        op_run(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);
        a = 16'hAAAA; b = 16'h1111; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_sum", {16'b0, sum}, 32'h0100);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        pop(16'h0100);
        repeat (5) @(negedge clk);
        check("bp_no_queued_op", {31'b0, out_valid}, 32'd0);

        // Reset after two nibble steps aborts the operation.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_sum", {16'b0, sum}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        repeat (6) @(negedge clk);
        check("abort_no_result", {31'b0, out_valid}, 32'd0);
        op_run(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0);
        pop(16'h3333);

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        op_run(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
        check("ovf_pos", {31'b0, ovf}, 32'd1);
        pop(16'h8000);
        op_run(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        check("ovf_none", {31'b0, ovf}, 32'd0);
        pop(16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
